// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the
// write-back stage (zero latency, priority) and a buffered MDU result queue.
//
// Build option:
//   RF_ARB_SQUASH_EN - when defined, a WB write kills any older queued entry
//                      with the same destination, so the stale MDU value is
//                      never written. When undefined, queued entries always
//                      retire in order and the hazard unit must keep WB off
//                      any register whose busy_mask bit is set.

module rf_wr_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // write-back stage
    input  logic                     wb_wr,
    input  logic [4:0]               wb_a3,
    input  logic [31:0]              wb_wd,
    // multiply/divide unit
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_a3,
    input  logic [31:0]              mdu_wd,
    output logic                     mdu_ready,
    // register file write port
    output logic                     rf_wr,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    // pipeline / hazard interface
    output logic                     wb_stall,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    WAIT_LIM = 8'(MAX_WAIT);

    // queue storage; vld marks occupied slots, live marks slots still to be written
    logic [4:0]       a3_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] live_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    // starvation tracking
    logic [7:0]       wait_q;
    logic [7:0]       wait_d;
    logic             stall_q;
    logic             stall_d;

    logic             q_empty;
    logic             head_live;
    logic             head_dead;
    logic             wb_use;
    logic             push;
    logic             pop;

    assign q_count  = count_q;
    assign wb_stall = stall_q;

    assign q_empty   = (count_q == '0);
    assign head_live = !q_empty && live_q[rd_ptr_q];
    assign head_dead = !q_empty && !live_q[rd_ptr_q];

    // WB owns the port unless stalled; writes to $0 never occupy it
    assign wb_use    = !stall_q && wb_wr && (wb_a3 != 5'd0);

    // no pop-through when full: readiness depends only on occupancy
    assign mdu_ready = rst && (count_q < FULL_CNT);
    assign push      = mdu_valid && mdu_ready;

    // dead heads retire silently; live heads retire only when WB leaves the port free
    assign pop       = head_dead || (head_live && !wb_use);

    // Write-port select: WB first, then a live queue head, else idle
    always_comb begin
        rf_wr = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (rst) begin
            if (wb_use) begin
                rf_wr = 1'b1;
                rf_a3 = wb_a3;
                rf_wd = wb_wd;
            end else if (head_live) begin
                rf_wr = 1'b1;
                rf_a3 = a3_q[rd_ptr_q];
                rf_wd = wd_q[rd_ptr_q];
            end
        end
    end

    // Pending-destination mask over occupied, still-live entries
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i] && live_q[i]) begin
                busy_mask[a3_q[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    // Starvation counter next state and forced-drain request
    always_comb begin
        wait_d = wait_q;
        if (pop || q_empty) begin
            wait_d = 8'd0;
        end else if (head_live && wb_use && (wait_q != 8'hFF)) begin
            wait_d = wait_q + 8'd1;
        end
        // stall lands in the cycle right after the MAX_WAIT-th blocked cycle
        stall_d = (wait_d == WAIT_LIM);
    end

    // Starvation counter and registered stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q  <= 8'd0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    // Result queue: squash, push, pop and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                a3_q[i] <= 5'd0;
                wd_q[i] <= 32'd0;
            end
            vld_q    <= '0;
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
`ifdef RF_ARB_SQUASH_EN
            // WB value is newer in program order than anything already queued
            if (wb_use) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (vld_q[i] && (a3_q[i] == wb_a3)) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
`endif
            // push slot is always empty here, so it never collides with a squash
            if (push) begin
                a3_q[wr_ptr_q]   <= mdu_a3;
                wd_q[wr_ptr_q]   <= mdu_wd;
                vld_q[wr_ptr_q]  <= 1'b1;
                live_q[wr_ptr_q] <= (mdu_a3 != 5'd0);
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr_q]  <= 1'b0;
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Testbench for rf_wr_arbiter: directed stimulus with a scoreboard of expected
// register-file writes, drained by a monitor that samples on the falling edge.

module tb_rf_wr_arbiter;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;

    logic        clk;
    logic        rst;
    logic        wb_wr;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        mdu_valid;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        wb_stall;
    logic [31:0] busy_mask;
    logic [2:0]  q_count;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] rf_model [32];
    int          checks;
    int          errors;

    rf_wr_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_wr     (wb_wr),
        .wb_a3     (wb_a3),
        .wb_wd     (wb_wd),
        .mdu_valid (mdu_valid),
        .mdu_a3    (mdu_a3),
        .mdu_wd    (mdu_wd),
        .mdu_ready (mdu_ready),
        .rf_wr     (rf_wr),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .wb_stall  (wb_stall),
        .busy_mask (busy_mask),
        .q_count   (q_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd);
        sb.push_back(wr_t'{a3: a3, wd: wd});
    endtask

    // Every committed write must match the oldest outstanding expectation
    task automatic monitor();
        wr_t exp;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && rf_wr === 1'b1) begin
                rf_model[rf_a3] = rf_wd;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write: got a3=%0d wd=0x%0h, expected no write",
                             rf_a3, rf_wd);
                end else begin
                    exp = sb.pop_front();
                    if (rf_a3 !== exp.a3 || rf_wd !== exp.wd) begin
                        errors++;
                        $display("FAIL rf_write: got a3=%0d wd=0x%0h, expected a3=%0d wd=0x%0h",
                                 rf_a3, rf_wd, exp.a3, exp.wd);
                    end
                end
            end
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q_count !== 3'd0 && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(q_count), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        rst       = 1'b1;
        wb_wr     = 1'b0;
        wb_a3     = 5'd0;
        wb_wd     = 32'd0;
        mdu_valid = 1'b0;
        mdu_a3    = 5'd0;
        mdu_wd    = 32'd0;
        fork
            monitor();
        join_none

        // reset held low with a pending MDU result
        #3;
        rst       = 1'b0;
        mdu_valid = 1'b1;
        mdu_a3    = 5'd3;
        mdu_wd    = 32'h33;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
            check("rst_rf_wr", 32'(rf_wr), 32'd0);
            check("rst_q_count", 32'(q_count), 32'd0);
        end
        tick();
        rst       = 1'b1;
        mdu_valid = 1'b0;
        at_neg();
        check("post_rst_mdu_ready", 32'(mdu_ready), 32'd1);
        check("post_rst_busy", busy_mask, 32'd0);
        check("post_rst_stall", 32'(wb_stall), 32'd0);

        // single push, WB idle: written the cycle after the push edge
        tick();
        mdu_valid = 1'b1;
        mdu_a3    = 5'd5;
        mdu_wd    = 32'h1234;
        expect_wr(5'd5, 32'h1234);
        at_neg();
        check("push_cycle_rf_wr", 32'(rf_wr), 32'd0);
        tick();
        mdu_valid = 1'b0;
        at_neg();
        check("single_busy", busy_mask, 32'h20);
        check("single_q_count", 32'(q_count), 32'd1);
        check("single_rf_wr", 32'(rf_wr), 32'd1);
        check("single_rf_a3", 32'(rf_a3), 32'd5);
        check("single_rf_wd", rf_wd, 32'h1234);
        tick();
        at_neg();
        check("single_drained", 32'(q_count), 32'd0);
        check("single_busy_clr", busy_mask, 32'd0);

        // starvation: WB hogs the port while the queue fills
        for (int c = 0; c < 10; c++) begin
            tick();
            wb_wr     = 1'b1;
            wb_a3     = 5'd9;
            wb_wd     = 32'h99;
            mdu_valid = (c < 5);
            mdu_a3    = 5'(c + 1);
            mdu_wd    = 32'(32'h100 + c + 1);
            if (c == 9) expect_wr(5'd1, 32'h101);
            else        expect_wr(5'd9, 32'h99);
            at_neg();
            check("starve_stall", 32'(wb_stall), 32'(c == 9));
            if (c == 4) begin
                check("full_q_count", 32'(q_count), 32'd4);
                check("full_mdu_ready", 32'(mdu_ready), 32'd0);
                check("full_busy", busy_mask, 32'h1E);
            end
            if (c == 8) check("full_reject", 32'(q_count), 32'd4);
            if (c == 9) check("stall_rf_a3", 32'(rf_a3), 32'd1);
        end
        tick();
        wb_wr     = 1'b0;
        mdu_valid = 1'b0;
        expect_wr(5'd2, 32'h102);
        expect_wr(5'd3, 32'h103);
        expect_wr(5'd4, 32'h104);
        at_neg();
        check("post_stall_stall", 32'(wb_stall), 32'd0);
        wait_empty("starve_drained");

        // WB write to $0 leaves the port to the queue head
        tick();
        mdu_valid = 1'b1;
        mdu_a3    = 5'd6;
        mdu_wd    = 32'h66;
        tick();
        mdu_valid = 1'b0;
        wb_wr     = 1'b1;
        wb_a3     = 5'd0;
        wb_wd     = 32'hDEAD;
        expect_wr(5'd6, 32'h66);
        at_neg();
        check("zero_dst_rf_wr", 32'(rf_wr), 32'd1);
        check("zero_dst_rf_a3", 32'(rf_a3), 32'd6);
        tick();
        wb_wr = 1'b0;
        at_neg();
        check("zero_dst_drained", 32'(q_count), 32'd0);

        // queued a3=7 followed by a newer WB write to r7
        tick();
        mdu_valid = 1'b1;
        mdu_a3    = 5'd7;
        mdu_wd    = 32'h77;
        tick();
        mdu_valid = 1'b0;
        wb_wr     = 1'b1;
        wb_a3     = 5'd7;
        wb_wd     = 32'hAA;
        expect_wr(5'd7, 32'hAA);
        at_neg();
        check("same_dst_busy", busy_mask, 32'h80);
        check("same_dst_rf_wd", rf_wd, 32'hAA);
        tick();
        wb_wr = 1'b0;
`ifdef RF_ARB_SQUASH_EN
        at_neg();
        check("squash_rf_wr", 32'(rf_wr), 32'd0);
        check("squash_busy", busy_mask, 32'd0);
        tick();
        at_neg();
        check("squash_drained", 32'(q_count), 32'd0);
        check("squash_r7", rf_model[7], 32'hAA);
`else
        expect_wr(5'd7, 32'h77);
        at_neg();
        check("nosquash_rf_wr", 32'(rf_wr), 32'd1);
        check("nosquash_busy", busy_mask, 32'h80);
        tick();
        at_neg();
        check("nosquash_drained", 32'(q_count), 32'd0);
        check("nosquash_r7", rf_model[7], 32'h77);
`endif

        // build q_count=2, then push and pop every cycle across the pointer wrap
        tick();
        wb_wr     = 1'b1;
        wb_a3     = 5'd10;
        wb_wd     = 32'hA0;
        mdu_valid = 1'b1;
        mdu_a3    = 5'd11;
        mdu_wd    = 32'hB1;
        expect_wr(5'd10, 32'hA0);
        at_neg();
        tick();
        mdu_a3 = 5'd12;
        mdu_wd = 32'hB2;
        expect_wr(5'd10, 32'hA0);
        at_neg();
        check("wrap_fill", 32'(q_count), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            wb_wr  = 1'b0;
            mdu_a3 = 5'(13 + k);
            mdu_wd = 32'(32'hB3 + k);
            expect_wr(5'(11 + k), 32'(32'hB1 + k));
            at_neg();
            check("wrap_q_count", 32'(q_count), 32'd2);
            check("wrap_rf_a3", 32'(rf_a3), 32'(11 + k));
        end
        tick();
        mdu_valid = 1'b0;
        expect_wr(5'd15, 32'hB5);
        expect_wr(5'd16, 32'hB6);
        wait_empty("wrap_drained");

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Shares the single register-file write port (RFWr/A3/WD, captured by the register file on the falling clock edge) between the in-order pipeline write-back stage and a long-latency multiply/divide unit (MDU). WB always has zero-latency priority; MDU results are buffered in a small FIFO and drained in idle WB cycles. A starvation counter forces a one-cycle pipeline stall when the queue is blocked too long. A busy mask exports pending destinations to the hazard unit.

## Interface
- DEPTH, 4: MDU result FIFO entries; power of two, ≥2.
- MAX_WAIT, 8: consecutive blocked cycles before a forced drain; 1..255.

- clk  in  1  system clock, rising-edge logic.
- rst  in  1  asynchronous, active-low reset.
- wb_wr  in  1  WB-stage write request.
- wb_a3  in  5  WB destination register.
- wb_wd  in  32  WB write data.
- mdu_valid  in  1  MDU result valid.
- mdu_a3  in  5  MDU destination register.
- mdu_wd  in  32  MDU result data.
- mdu_ready  out  1  FIFO can accept; push on rising edge when valid && ready.
- rf_wr  out  1  to register file RFWr.
- rf_a3  out  5  to register file A3.
- rf_wd  out  32  to register file WD.
- wb_stall  out  1  registered; pipeline must freeze WB and re-present the same request next cycle.
- busy_mask  out  32  bit r = 1 while a live queued write targets r; bit 0 always 0.
- q_count  out  $clog2(DEPTH)+1  occupied entries, including dead ones.

## Operation
- Port select each cycle (combinational):
  - if wb_stall=0 and wb_wr=1 and wb_a3≠0, WB drives rf_* directly;
  - otherwise, if the head entry is live, the head drives rf_* with rf_wr=1 and pops at the next edge;
  - otherwise rf_wr=0.
- WB writes to $0 produce rf_wr=0 and count as not using the port.
- A dead head pops at the next edge whenever it is at the head; it never asserts rf_wr and does not consume the port.
- Push rules:
  - mdu_ready = (q_count < DEPTH); there is no pop-through when full.
  - A pushed mdu_a3=0 is accepted and stored dead.
- busy_mask is combinational over valid live entries.
- Starvation counter (8-bit):
  - increments each edge where the head is live, wb_stall=0, and WB uses the port;
  - clears on any pop or when the queue is empty.
  - When the counter equals MAX_WAIT, wb_stall is set for exactly one cycle; the head drains in that cycle and the counter clears.
  - wb_wr is ignored while wb_stall=1.
- Reset (rst=0):
  - queue emptied, counter=0, wb_stall=0, q_count=0, busy_mask=0;
  - rf_wr forced 0 and mdu_ready forced 0 while rst=0;
  - mdu_ready rises in the first cycle after release.
- Reset mid-operation discards all queued results without writing them.

## Timing
- WB path latency is 0: rf_* follows wb_* in the same cycle, and the register file commits on that cycle's falling edge.
- A pushed MDU result is drainable from the cycle after the push edge. It never reaches rf_* in its push cycle.
- Best-case MDU latency: push edge N, rf_wr high in cycle N+1, committed on cycle N+1 falling edge, popped at edge N+2.
- Simultaneous push and pop in one edge: q_count unchanged and pointers both advance; legal when not full.
- Pointers wrap modulo DEPTH.
- Worst-case MDU wait is MAX_WAIT blocked cycles, then a guaranteed 1-cycle drain.
- Writes leave the FIFO in push order.

## Configuration
- RF_ARB_SQUASH_EN defined:
  - a WB write that uses the port at edge N marks every entry already queued before edge N with the same a3 as dead, since the WB value is newer in program order;
  - a push at edge N with the same a3 stays live;
  - dead entries clear their busy_mask bit immediately.
- Not defined:
  - no squash; entries are written in order regardless of later WB writes;
  - the hazard unit must not let WB target any register whose busy_mask bit is set.

## Test plan
- Reset with mdu_valid=1 and rst held low for 3 cycles -> mdu_ready=0, rf_wr=0, q_count=0; mdu_ready=1 in the first cycle after release.
- wb_wr=0 and one push {a3=5, wd=0x1234} at edge N -> busy_mask=0x20 after edge N; rf_wr=1, rf_a3=5, rf_wd=0x1234 in cycle N+1; q_count=0 after edge N+2.
- 4 pushes {a3=1..4} with wb_wr=1 (a3=9) continuously -> mdu_ready=0 at q_count=4; wb_stall pulses once after 8 blocked cycles; a3=1 is written in that cycle and rf_a3≠9 then.
- wb_wr=1 with a3=0 and a queued live entry -> that cycle rf_wr=1 with the queue head, not $0.
- Squash, RF_ARB_SQUASH_EN defined: queued a3=7, then WB write a3=7 wd=0xAA -> busy_mask bit 7 clears; the entry pops with no rf_wr; register 7 keeps 0xAA.
- Squash, RF_ARB_SQUASH_EN undefined: same stimulus -> the queued a3=7 entry is written after WB.
- Simultaneous push and pop at q_count=2 with DEPTH=4 and pointer wrap -> q_count stays 2; FIFO order preserved across the wrap.
